// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and default sizes for the memory-port arbiter
package mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_LINE_WIDTH   = 128;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef logic [DEF_LINE_WIDTH-1:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_I,
    ARB_GRANT_D
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between I-side and D-side cache miss paths
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  // The streak counter is 3 bits wide, so the limit must fit in it.
  localparam logic [2:0] STREAK_MAX = 3'(STARVE_LIMIT);

  arb_state_t            state_q, state_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            streak_q, streak_d;
  logic                  pend_i, pend_d, force_i;

  assign pend_i  = i_read;
  assign pend_d  = d_read | d_write;
  // I-side wins a tie only once D has been granted STARVE_LIMIT times in a row over it.
  assign force_i = pend_i && (streak_q == STREAK_MAX);

  // Next-state, grant capture, streak update and completion pulses.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    streak_d = streak_q;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pend_d && !force_i) begin
          state_d = ARB_GRANT_D;
          addr_d  = d_address;
          // A simultaneous read+write is resolved as a write.
          wr_d    = d_write;
          rd_d    = ~d_write;
          if (d_write) begin
            wdata_d = d_wdata;
          end
          if (!i_read) begin
            streak_d = 3'd0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 3'd1;
          end
        end else if (pend_i) begin
          state_d  = ARB_GRANT_I;
          addr_d   = i_address;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          streak_d = 3'd0;
        end
      end
      ARB_GRANT_I: begin
        if (mem_resp) begin
          i_resp  = 1'b1;
          state_d = ARB_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      ARB_GRANT_D: begin
        if (mem_resp) begin
          d_resp  = 1'b1;
          state_d = ARB_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and grant registers; reset abandons any in-flight memory operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      streak_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      streak_q <= streak_d;
    end
  end

  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;

endmodule
